usbfs_debug_uart_tx: RTL and testbench
======================================

USBFS_DEBUG_UART_TX -- requirements
Module: usbfs_debug_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 521, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_AW, default 10, meaning FIFO address width (depth 2**FIFO_AW bytes, legal range 2..12).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port debug_en  input  1  one-cycle strobe; debug_data is valid this cycle.
REQ-006 The block SHALL have port debug_data  input  8  ASCII byte from the USB debug monitor.
REQ-007 The block SHALL have port uart_tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-008 The block SHALL have port debug_ovf  output  1  sticky flag: at least one byte was dropped because the FIFO was full.
REQ-009 The block SHALL have port busy  output  1  high when the FIFO is non-empty or a frame is in progress.

Function
REQ-010 The block SHALL hold a byte FIFO with depth 2**FIFO_AW and a count register FIFO_AW+1 bits wide.
REQ-011 On debug_en=1 with count < depth, the block SHALL write debug_data at that edge.
REQ-012 On debug_en=1 with count == depth, the block SHALL drop the byte and set debug_ovf, even when a pop occurs in the same cycle.
REQ-013 A write and a pop in the same cycle SHALL leave count unchanged; pointers SHALL wrap modulo depth.
REQ-014 The TX FSM SHALL have states IDLE, LOAD, START, DATA, STOP.
REQ-015 IDLE: uart_tx=1; if count > 0 (registered value), the FSM SHALL pop one byte and go to LOAD.
REQ-016 LOAD: uart_tx=1 for one cycle; the popped byte SHALL be latched into the shift register; next state START.
REQ-017 START: uart_tx=0 for CLK_DIV cycles, then DATA.
REQ-018 DATA: the block SHALL send bits 0..7 LSB first, each for CLK_DIV cycles, using a 3-bit bit counter, then go to STOP.
REQ-019 STOP: uart_tx=1 for CLK_DIV cycles; then the FSM SHALL return to IDLE.
REQ-020 The baud counter SHALL be 16 bits, SHALL reload at each state/bit boundary, and SHALL be unaffected by FIFO activity.
REQ-021 Frame length SHALL be exactly 10*CLK_DIV cycles, and the gap between back-to-back frames SHALL be exactly 2 cycles (IDLE + LOAD).
REQ-022 Latency: with the FSM in IDLE and the FIFO empty, a debug_en sampled at edge T SHALL produce uart_tx=0 from edge T+3.
REQ-023 uart_tx SHALL be driven from a register (glitch-free).
REQ-024 debug_ovf SHALL clear only on rst.
REQ-025 busy SHALL equal (count != 0) OR (state != IDLE).

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL set: uart_tx=1, debug_ovf=0, state=IDLE, count=0, read/write pointers=0, and baud and bit counters=0.
REQ-027 On rst asserted mid-frame, the block SHALL abort the frame and drive uart_tx high from the next edge, and SHALL discard all buffered bytes.
REQ-028 While rst=1, debug_en SHALL be ignored.
REQ-029 FIFO storage contents SHALL NOT require reset.

Verification
REQ-030 With CLK_DIV=4, a single 0x41 SHALL produce uart_tx = 0 x4, then 1,0,0,0,0,0,1,0 each x4, then 1 x4, after which the FSM is in IDLE and busy=0.
REQ-031 With CLK_DIV=4, bytes "\n","-",">" on 3 consecutive cycles SHALL produce three frames carrying 0x0A, 0x2D and 0x3E, 40 cycles each, separated by 2-cycle idle-high gaps, with debug_ovf=0.
REQ-032 With FIFO_AW=2 and CLK_DIV=8, 7 bytes 0x30..0x36 written on consecutive cycles while idle SHALL transmit 0x30..0x34 only, and debug_ovf SHALL be 1 from the edge that drops 0x35.
REQ-033 With rst pulsed during the DATA bit 3 of a frame while 3 bytes are queued, uart_tx SHALL go high at the next edge, busy=0, debug_ovf=0, and no further frames SHALL be sent.
REQ-034 With the FIFO full (depth 4) and debug_en coinciding with an IDLE pop, the byte SHALL be dropped, debug_ovf SHALL be set, and count SHALL go from 4 to 3.
REQ-035 With 2**FIFO_AW+3 bytes written, each after the previous frame ends, pointer wrap-around SHALL be exercised and all bytes SHALL be received in order.

Source files
------------

// File: rtl/usbfs_debug_uart_tx.sv
// rtl/usbfs_debug_uart_tx.sv - byte FIFO feeding an 8N1 UART transmitter for USB debug output
// uart_tx is registered from the current state, so the line trails the FSM by one cycle.
module usbfs_debug_uart_tx #(
  parameter int CLK_DIV = 521,
  parameter int FIFO_AW = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       debug_en,
  input  logic [7:0] debug_data,
  output logic       uart_tx,
  output logic       debug_ovf,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam int               DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [15:0]      BAUD_LAST = 16'(CLK_DIV - 1);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         pop_byte;

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic baud_done;

  // A full FIFO drops the incoming byte even if the transmitter frees a slot this cycle.
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = debug_en & ~fifo_full & ~rst;
  assign pop        = (state == IDLE) & ~fifo_empty & ~rst;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign busy       = ~fifo_empty | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= debug_data;
    end
    if (pop) begin
      pop_byte <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      debug_ovf <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (debug_en && fifo_full) begin
        debug_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          uart_tx   <= 1'b1;
          shift_reg <= pop_byte;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          state     <= START;
        end
        START: begin
          uart_tx <= 1'b0;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          uart_tx <= shift_reg[bit_cnt];
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbfs_debug_uart_tx.sv
// tb/tb_usbfs_debug_uart_tx.sv - randomized and directed bench for usbfs_debug_uart_tx
// A timing model predicts the line, busy and overflow every cycle; a line decoder recovers the bytes.
module tb_usbfs_debug_uart_tx;

  localparam int C     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       debug_en = 1'b0;
  logic [7:0] debug_data = 8'h00;
  logic       uart_tx;
  logic       debug_ovf;
  logic       busy;

  usbfs_debug_uart_tx #(.CLK_DIV(C), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .debug_en   (debug_en),
    .debug_data (debug_data),
    .uart_tx    (uart_tx),
    .debug_ovf  (debug_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, transmitter as "last pop edge"; frame timing by arithmetic.
  int         m_edge = 0;
  int         m_pop_edge = -1000000;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;
  bit         m_full;
  bit         m_do_pop;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_q.delete();
      m_pop_edge = -1000000;
      m_ovf      = 1'b0;
      chk_en     = 1'b1;
    end else begin
      m_full   = (m_q.size() == DEPTH);
      m_do_pop = (m_q.size() != 0) && (m_edge >= m_pop_edge + 10*C + 2);
      if (m_do_pop) begin
        m_byte = m_q.pop_front();
        m_sent.push_back(m_byte);
        m_pop_edge = m_edge;
      end
      if (debug_en) begin
        if (m_full) m_ovf = 1'b1;
        else        m_q.push_back(debug_data);
      end
    end
  end

  int   c_d;
  int   c_j;
  logic c_tx;
  logic c_busy;

  always @(negedge clk) begin
    if (chk_en) begin
      c_d = m_edge - m_pop_edge;
      c_j = c_d - 2;
      if (c_j < 0 || c_j >= 10*C) c_tx = 1'b1;
      else if (c_j < C)           c_tx = 1'b0;
      else if (c_j < 9*C)         c_tx = m_byte[c_j/C - 1];
      else                        c_tx = 1'b1;
      c_busy = (m_q.size() != 0) || (c_d >= 0 && c_d <= 10*C);
      check("uart_tx", {31'd0, uart_tx}, {31'd0, c_tx});
      check("busy", {31'd0, busy}, {31'd0, c_busy});
      check("debug_ovf", {31'd0, debug_ovf}, {31'd0, m_ovf});
    end
  end

  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = 8'h00;
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == C/2 + 9*C) begin
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end else if (rx_cnt >= C + C/2 && ((rx_cnt - C/2) % C) == 0) begin
        rx_byte[(rx_cnt - C/2)/C - 1] = uart_tx;
      end
    end
  end

  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    debug_en   = 1'b1;
    debug_data = b;
    tick();
    debug_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] got;
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hxxxxxxxx;
      check(tag, got, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ovf", {31'd0, debug_ovf}, 32'd0);

    // single 'A'
    rx_q.delete();
    exp_q.delete();
    push_byte(8'h41);
    wait_idle();
    exp_q.push_back(8'h41);
    check_rx("single_a");
    check("single_a_busy", {31'd0, busy}, 32'd0);

    // prompt string on consecutive cycles
    rx_q.delete();
    exp_q.delete();
    debug_en = 1'b1;
    debug_data = 8'h0A; tick();
    debug_data = 8'h2D; tick();
    debug_data = 8'h3E; tick();
    debug_en = 1'b0;
    wait_idle();
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h2D);
    exp_q.push_back(8'h3E);
    check_rx("prompt");
    check("prompt_ovf", {31'd0, debug_ovf}, 32'd0);

    // overflow of a depth-4 FIFO
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      push_byte(8'h30 + 8'(i));
      check("ovf_seq", {31'd0, debug_ovf}, (i >= 5) ? 32'd1 : 32'd0);
    end
    wait_idle();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h30 + 8'(i));
    check_rx("overflow");
    check("overflow_sticky", {31'd0, debug_ovf}, 32'd1);

    // reset in the middle of data bit 3 with three bytes queued
    pulse_reset();
    for (int i = 0; i < 4; i++) push_byte(8'h51 + 8'(i));
    begin
      int n = 0;
      while (uart_tx !== 1'b0 && n < 50) begin
        tick();
        n++;
      end
      check("start_timeout", {31'd0, uart_tx}, 32'd0);
    end
    repeat (4*C + 1) tick();
    rst = 1'b1;
    tick();
    check("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ovf", {31'd0, debug_ovf}, 32'd0);
    rst = 1'b0;
    repeat (300) tick();
    check("abort_no_frames", rx_q.size(), 32'd0);
    check("abort_still_idle", {31'd0, busy}, 32'd0);

    // full FIFO, write coincides with the IDLE pop
    pulse_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
    repeat (10*C - 2) tick();
    push_byte(8'h7A);
    check("full_pop_ovf", {31'd0, debug_ovf}, 32'd1);
    wait_idle();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h61 + 8'(i));
    check_rx("full_pop");

    // pointer wrap with one byte per frame
    pulse_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b);
      wait_idle();
    end
    check_rx("wrap");

    // random traffic against the model
    pulse_reset();
    m_sent.delete();
    for (int i = 0; i < 1000; i++) begin
      debug_en   = ($urandom_range(0, 11) == 0);
      debug_data = 8'($urandom);
      tick();
    end
    debug_en = 1'b0;
    wait_idle();
    foreach (m_sent[i]) exp_q.push_back(m_sent[i]);
    check_rx("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
